// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus bundle for the data-memory arbiter.
// Groups the processor-side, host-side, halt and memory-macro signals.
// slave  : arbiter view (drives stall/grant/memory pins)
// master : environment view (processor, host, memory macro)
interface dmem_arbiter_if;
  // processor side
  logic        cpu_mem_wr;
  logic [7:0]  cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic [31:0] cpu_mem_rdata;
  logic        cpu_stall;
  // host/debug side
  logic        host_req;
  logic        host_wr;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic [31:0] host_rdata;
  logic        host_valid;
  // halt control
  logic        halt_req;
  logic        halted;
  // memory macro
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_mem_wr, cpu_mem_addr, cpu_mem_wdata,
    output cpu_mem_rdata, cpu_stall,
    input  host_req, host_wr, host_addr, host_wdata,
    output host_gnt, host_rdata, host_valid,
    input  halt_req,
    output halted,
    output mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_mem_wr, cpu_mem_addr, cpu_mem_wdata,
    input  cpu_mem_rdata, cpu_stall,
    output host_req, host_wr, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_valid,
    output halt_req,
    input  halted,
    input  mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the processor
// and a host/debug port. Host accesses stall the processor; a burst limit
// forces one processor cycle after MAX_HOST_BURST consecutive host grants
// unless the processor is halted.
// Optional macro DMEM_ARB_STATS_EN adds saturating stall/host-access counters.
module dmem_arbiter #(
  parameter int unsigned MAX_HOST_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  dmem_arbiter_if.slave    bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      host_acc_cnt
`endif
);

  typedef enum logic {ST_CPU, ST_HOST} state_t;

  localparam logic [4:0] MAX_B = 5'(MAX_HOST_BURST);

  state_t      state_q, state_d;
  logic [3:0]  burst_q, burst_d;
  logic        halted_q;
  logic [31:0] host_rdata_q;
  logic        host_valid_q;
  logic        host_own;
  logic [4:0]  burst_sum;
  logic        limit_hit;

  assign host_own = (state_q == ST_HOST);

  // Next-state and burst counter; count saturates so a long halted burst
  // cannot wrap and a >= compare forces the CPU slot right after halt drops.
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    burst_sum = {1'b0, burst_q} + 5'd1;
    limit_hit = ~halted_q && (burst_sum >= MAX_B);
    unique case (state_q)
      ST_CPU: begin
        burst_d = '0;
        if (bus.host_req) state_d = ST_HOST;
      end
      ST_HOST: begin
        burst_d = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
        if (!bus.host_req || limit_hit) begin
          state_d = ST_CPU;
          burst_d = '0;
        end
      end
      default: begin
        state_d = ST_CPU;
        burst_d = '0;
      end
    endcase
  end

  // FSM state, halt status and registered host read data/valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CPU;
      burst_q      <= '0;
      halted_q     <= 1'b0;
      host_rdata_q <= '0;
      host_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      halted_q     <= bus.halt_req;
      host_valid_q <= host_own && !bus.host_wr;
      if (host_own && !bus.host_wr) host_rdata_q <= bus.mem_rdata;
    end
  end

  // Memory-pin mux; writes are blocked combinationally during reset
  always_comb begin
    if (host_own) begin
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
      bus.mem_wr    = bus.host_wr && !rst;
    end else begin
      bus.mem_addr  = bus.cpu_mem_addr;
      bus.mem_wdata = bus.cpu_mem_wdata;
      bus.mem_wr    = bus.cpu_mem_wr && !halted_q && !rst;
    end
  end

  assign bus.cpu_mem_rdata = bus.mem_rdata;
  assign bus.cpu_stall     = host_own || halted_q;
  assign bus.host_gnt      = host_own;
  assign bus.host_rdata    = host_rdata_q;
  assign bus.host_valid    = host_valid_q;
  assign bus.halted        = halted_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] host_acc_cnt_q;

  // Saturating activity counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q    <= '0;
      host_acc_cnt_q <= '0;
    end else begin
      if (bus.cpu_stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (host_own && (host_acc_cnt_q != 16'hFFFF))
        host_acc_cnt_q <= host_acc_cnt_q + 16'd1;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign host_acc_cnt = host_acc_cnt_q;
`endif

endmodule
